asic_clkgate_ctrl: RTL and testbench

- Enable-side controller for an integrated AND clock-gating cell.
- Runs on the free-running clock and watches activity from the downstream gated domain.
- Drops the gate enable after a programmable idle period and restores it on activity or an explicit wake request.
- Provides a 4-phase wake request/acknowledge handshake so upstream logic knows when the gated clock is running and stable.

---
 rtl/asic_clkgate_ctrl.sv | 95 +++++++++
 tb/tb_asic_clkgate_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/asic_clkgate_ctrl.sv
// rtl/asic_clkgate_ctrl.sv - enable-side controller for an integrated AND clock-gating cell
module asic_clkgate_ctrl #(
  parameter int IDLE   = 16,
  parameter int SETTLE = 2,
  parameter int CW     = 8
) (
  input  logic clk,
  input  logic nreset,
  input  logic gate_en,
  input  logic busy,
  input  logic wake_req,
  output logic wake_ack,
  output logic en,
  output logic gated
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  // Thresholds are compared at counter width; out-of-range values are illegal anyway.
  localparam logic [CW-1:0] IDLE_C   = CW'(IDLE);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          en_q;
  logic          gated_q;
  logic          ack_q;

  logic          act;
  logic [CW-1:0] cnt_inc;

  // Anything that needs the gated clock running counts as activity.
  assign act     = busy | wake_req | ~gate_en;
  assign cnt_inc = cnt_q + CW'(1);

  // Gating FSM with idle/settle counter and registered enable, status and acknowledge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      gated_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      // Acknowledge only once the clock is running and settled; drops with the request.
      ack_q <= wake_req & (state_q == ST_RUN);
      case (state_q)
        ST_RUN: begin
          if (act) begin
            cnt_q <= '0;
          end else if (cnt_q == IDLE_C) begin
            state_q <= ST_GATED;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            gated_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_GATED: begin
          cnt_q <= '0;
          if (act) begin
            state_q <= ST_WAKE;
            en_q    <= 1'b1;
            gated_q <= 1'b0;
          end
        end
        ST_WAKE: begin
          // Settle window always runs to completion regardless of inputs.
          if (cnt_inc == SETTLE_C) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
          en_q    <= 1'b1;
          gated_q <= 1'b0;
        end
      endcase
    end
  end

  assign en       = en_q;
  assign gated    = gated_q;
  assign wake_ack = ack_q;

endmodule

// File: tb/tb_asic_clkgate_ctrl.sv
// tb/tb_asic_clkgate_ctrl.sv - scoreboard testbench for asic_clkgate_ctrl
module tb_asic_clkgate_ctrl;

  localparam int IDLE   = 16;
  localparam int SETTLE = 2;
  localparam int CW     = 8;

  logic clk      = 1'b0;
  logic nreset   = 1'b1;
  logic gate_en  = 1'b1;
  logic busy     = 1'b0;
  logic wake_req = 1'b0;
  logic wake_ack;
  logic en;
  logic gated;

  asic_clkgate_ctrl #(
    .IDLE  (IDLE),
    .SETTLE(SETTLE),
    .CW    (CW)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .gate_en (gate_en),
    .busy    (busy),
    .wake_req(wake_req),
    .wake_ack(wake_ack),
    .en      (en),
    .gated   (gated)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic en;
    logic gated;
    logic ack;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: mode 0 = running, 1 = gated off, 2 = waking.
  int   m_mode;
  int   m_idle;
  int   m_wake;
  logic m_en;
  logic m_gated;
  logic m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_idle  = 0;
    m_wake  = 0;
    m_en    = 1'b1;
    m_gated = 1'b0;
    m_ack   = 1'b0;
  endtask

  task automatic model_step();
    logic a;
    a     = busy | wake_req | ~gate_en;
    m_ack = wake_req && (m_mode == 0);
    if (m_mode == 0) begin
      if (a) m_idle = 0;
      else if (m_idle == IDLE) begin
        m_mode  = 1;
        m_idle  = 0;
        m_en    = 1'b0;
        m_gated = 1'b1;
      end else m_idle++;
    end else if (m_mode == 1) begin
      if (a) begin
        m_mode  = 2;
        m_wake  = 0;
        m_en    = 1'b1;
        m_gated = 1'b0;
      end
    end else begin
      m_wake++;
      if (m_wake == SETTLE) begin
        m_mode = 0;
        m_idle = 0;
      end
    end
  endtask

  task automatic cycle(input string tag);
    exp_t e;
    model_step();
    e.en    = m_en;
    e.gated = m_gated;
    e.ack   = m_ack;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, "/en"}, en, e.en);
    check({tag, "/gated"}, gated, e.gated);
    check({tag, "/ack"}, wake_ack, e.ack);
  endtask

  task automatic async_reset(input string tag);
    nreset = 1'b0;
    #1;
    check({tag, "/en"}, en, 1);
    check({tag, "/gated"}, gated, 0);
    check({tag, "/ack"}, wake_ack, 0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    model_reset();
  endtask

  task automatic run_until_en_low(output int n, input string tag);
    n = 0;
    do begin
      cycle(tag);
      n++;
    end while (en === 1'b1 && n < 60);
  endtask

  task automatic run_until_ack(output int n, input string tag);
    n = 0;
    do begin
      cycle(tag);
      n++;
    end while (wake_ack !== 1'b1 && n < 60);
  endtask

  task automatic busy_wake(input string tag);
    busy = 1'b1;
    cycle({tag, "_wake"});
    busy = 1'b0;
    repeat (SETTLE) cycle({tag, "_settle"});
  endtask

  initial begin
    int n;
    int en_low;
    int ack_hi;
    model_reset();
    #2;
    async_reset("rst");

    run_until_en_low(n, "idle0");
    check("idle_to_gate", n, IDLE + 1);
    check("gated_flag", gated, 1);

    wake_req = 1'b1;
    run_until_ack(n, "wreq");
    check("ack_lat_gated", n, SETTLE + 2);
    repeat (6) cycle("hold");
    wake_req = 1'b0;
    cycle("drop");
    check("ack_drop", wake_ack, 0);
    run_until_en_low(n, "req_idle");
    check("req_to_gate", n, IDLE);

    busy_wake("b1");
    repeat (IDLE - 1) cycle("idle15");
    busy = 1'b1;
    cycle("pulse15");
    busy = 1'b0;
    run_until_en_low(n, "after15");
    check("restart_15", n, IDLE + 1);

    busy_wake("b2");
    repeat (IDLE) cycle("idle16");
    busy = 1'b1;
    cycle("hit_idle");
    check("hit_idle_en", en, 1);
    busy = 1'b0;
    run_until_en_low(n, "after_hit");
    check("restart_hit", n, IDLE + 1);

    gate_en = 1'b0;
    en_low  = 0;
    ack_hi  = 0;
    for (int i = 0; i < 100; i++) begin
      cycle("force_on");
      if (en !== 1'b1) en_low++;
      if (wake_ack !== 1'b0) ack_hi++;
    end
    check("force_en_low", en_low, 0);
    check("force_ack", ack_hi, 0);
    gate_en = 1'b1;
    run_until_en_low(n, "ge_idle");
    check("ge_to_gate", n, IDLE + 1);
    gate_en = 1'b0;
    cycle("ge_wake");
    check("ge_wake_en", en, 1);
    gate_en = 1'b1;
    repeat (SETTLE + 2) cycle("ge_settle");

    wake_req = 1'b1;
    run_until_ack(n, "wreq_run");
    check("ack_lat_run", n, 1);
    wake_req = 1'b0;
    cycle("drop_run");

    run_until_en_low(n, "to_gated");
    check("pre_rst_gated", gated, 1);
    #2;
    async_reset("rst_gated");

    run_until_en_low(n, "to_gated2");
    busy = 1'b1;
    cycle("into_wake");
    busy = 1'b0;
    #2;
    async_reset("rst_wake");

    for (int i = 0; i < 400; i++) begin
      busy     = ($urandom_range(0, 19) == 0);
      gate_en  = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 24) == 0) wake_req = ~wake_req;
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
